// File: rtl/riscv_memory_pkg.sv
// Shared types and constants for the RISC-V memory port.
// Holds the port state encoding and the default RAM depth.
package riscv_memory_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 4096;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } port_state_t;

endpackage

// File: rtl/riscv_sram_1rw.sv
// Single-port synchronous RAM, write-first, no array reset.
// Ports: clk, en, we, addr, wdata, rdata (held when en is low).
module riscv_sram_1rw #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/riscv_memory_port.sv
// Word RAM bus port: one-cycle ack, optional clear after reset.
// Ports: clock, reset(n), memory_address/read/write/out in;
// memory_in, memory_ready, memory_address_requested, busy out.
// Define MEMORY_PORT_CLEAR_EN to fill RAM with CLEAR_VALUE
// after reset (busy high meanwhile).
module riscv_memory_port
  import riscv_memory_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] memory_out,
  output logic [31:0] memory_in,
  output logic        memory_ready,
  output logic [31:0] memory_address_requested,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [AW-1:0] word_idx;
  logic          out_of_range;
  logic          serve;
  logic          clr_active;
  logic [AW-1:0] clr_idx;
  logic          accept;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          ready_q;
  logic [31:0]   addr_q;
  logic          oor_q;
  logic          valid_q;
  logic          unused_lsb;

  assign word_idx     = memory_address[AW+1:2];
  assign out_of_range = |memory_address[31:AW+2];
  assign unused_lsb   = ^memory_address[1:0];

`ifdef MEMORY_PORT_CLEAR_EN
  port_state_t   state;
  logic [AW-1:0] clr_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(DEPTH_WORDS - 1))
        state <= ST_SERVE;
    end
  end

  assign serve      = (state == ST_SERVE);
  assign clr_active = (state == ST_CLEAR);
  assign clr_idx    = clr_cnt;
  assign busy       = clr_active;
`else
  assign serve      = 1'b1;
  assign clr_active = 1'b0;
  assign clr_idx    = '0;
  assign busy       = 1'b0;
`endif

  assign accept = serve & (memory_read | memory_write);

  // RAM only toggles on clear writes or in-range accepts, so its
  // read register already holds the last answer between acks.
  assign ram_en    = clr_active | (accept & ~out_of_range);
  assign ram_we    = clr_active | memory_write;
  assign ram_addr  = clr_active ? clr_idx : word_idx;
  assign ram_wdata = clr_active ? CLEAR_VALUE : memory_out;

  riscv_sram_1rw #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clock),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ready_q <= accept;
      if (accept) begin
        addr_q  <= memory_address;
        oor_q   <= out_of_range;
        valid_q <= 1'b1;
      end
    end
  end

  // valid_q masks the unreset RAM register until the first ack.
  assign memory_in = (valid_q && !oor_q) ? ram_rdata : 32'h0;
  assign memory_ready             = ready_q;
  assign memory_address_requested = addr_q;

endmodule
